chan14_gyro_sequencer: RTL

//  Output channel 14 holding register plus gyro torque pulse sequencer, downstream of the channel I/O decode stage.

---
 rtl/chan14_gyro_sequencer_if.sv | 37 +++
 rtl/chan14_gyro_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/chan14_gyro_sequencer_if.sv
// rtl/chan14_gyro_sequencer_if.sv - channel 14 register and gyro pulse signal bundle
interface chan14_gyro_sequencer_if #(
  parameter int CNT_W = 15
);
  // channel 14 register access
  logic              WCH14_n;
  logic              CCH14;
  logic              RCH14_n;
  logic [14:0]       CHWL_n;
  logic [14:0]       CHOR14_n;
  logic [14:0]       CH14Q;

  // gyro timing strobes and magnitude load
  logic              GTSET;
  logic              GTRST_n;
  logic              GTONE;
  logic              GYROD_LD;
  logic [CNT_W-1:0]  GYROD_CNT;

  // gyro torque outputs
  logic              GYRO_P;
  logic              GYRO_M;
  logic              GYRO_BUSY;
  logic              GYRO_DONE;

  modport master (
    output WCH14_n, CCH14, RCH14_n, CHWL_n,
    output GTSET, GTRST_n, GTONE, GYROD_LD, GYROD_CNT,
    input  CHOR14_n, CH14Q, GYRO_P, GYRO_M, GYRO_BUSY, GYRO_DONE
  );

  modport slave (
    input  WCH14_n, CCH14, RCH14_n, CHWL_n,
    input  GTSET, GTRST_n, GTONE, GYROD_LD, GYROD_CNT,
    output CHOR14_n, CH14Q, GYRO_P, GYRO_M, GYRO_BUSY, GYRO_DONE
  );
endinterface

// File: rtl/chan14_gyro_sequencer.sv
// rtl/chan14_gyro_sequencer.sv - channel 14 holding register and gyro torque pulse sequencer
module chan14_gyro_sequencer #(
  parameter int CNT_W   = 15,
  parameter int PULSE_W = 2
) (
  input  logic SIM_CLK,
  input  logic SIM_RST,
  input  logic VCC,
  input  logic GND,
  input  logic GOJAM,
  chan14_gyro_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_TORQUE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;

  logic             rst_all;
  logic [14:0]      ch14q;
  logic [CNT_W-1:0] count;
  logic [2:0]       pulse_cnt;
  logic             pulse_neg;

  logic             gtset_q;
  logic             gtrst_q;
  logic             gtone_q;
  logic             gtset_rise;
  logic             gtrst_fall;
  logic             gtone_rise;

  logic             gyenab;
  logic             gyact;
  logic             sign_minus;
  logic             pulse_active;
  logic             pulse_start;
  logic             pulse_abort;
  logic             done_now;

  // Supply pins carry no logic; fold them into a sink so they are consumed.
  logic             unused_supply;
  assign unused_supply = VCC ^ GND;

  // GOJAM restarts the block exactly like the simulation reset.
  assign rst_all = SIM_RST | GOJAM;

  // Control bits live in the holding register: bit9 sign, bit10 GYENAB, bit11 GYACT.
  assign sign_minus   = ch14q[8];
  assign gyenab       = ch14q[9];
  assign gyact        = ch14q[10];
  assign pulse_active = (pulse_cnt != 3'd0);

  assign gtset_rise = bus.GTSET & ~gtset_q;
  assign gtrst_fall = ~bus.GTRST_n & gtrst_q;
  assign gtone_rise = bus.GTONE & ~gtone_q;

  // Strobe history for edge detection; cleared to each strobe's inactive level.
  always_ff @(posedge SIM_CLK) begin
    if (rst_all) begin
      gtset_q <= 1'b0;
      gtrst_q <= 1'b1;
      gtone_q <= 1'b0;
    end else begin
      gtset_q <= bus.GTSET;
      gtrst_q <= bus.GTRST_n;
      gtone_q <= bus.GTONE;
    end
  end

  // State register.
  always_ff @(posedge SIM_CLK) begin
    if (rst_all) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, pulse start/abort and completion decode.
  always_comb begin
    state_next  = state;
    pulse_start = 1'b0;
    pulse_abort = 1'b0;
    done_now    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (gyenab && gyact) begin
          if (count != '0) begin
            state_next = S_ARMED;
          end else begin
            done_now = 1'b1;
          end
        end
      end
      S_ARMED: begin
        if (!(gyenab && gyact)) begin
          state_next  = S_IDLE;
          pulse_abort = 1'b1;
        end else if (gtset_rise) begin
          state_next = S_TORQUE;
        end
      end
      S_TORQUE: begin
        if (!gyenab) begin
          state_next  = S_IDLE;
          pulse_abort = 1'b1;
        end else begin
          if (gtone_rise && !pulse_active && (count != '0)) begin
            pulse_start = 1'b1;
          end
          // Frame end judges the count left after any pulse started this same cycle.
          if (gtrst_fall) begin
            if (pulse_start ? (count > CNT_W'(1)) : (count != '0)) begin
              state_next = S_ARMED;
            end else begin
              state_next = S_DONE;
            end
          end else if ((count == '0) && !pulse_active) begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_now   = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Holding register: write beats clear, clear beats the hardware GYACT clear on completion.
  always_ff @(posedge SIM_CLK) begin
    if (rst_all) begin
      ch14q <= '0;
    end else if (!bus.WCH14_n) begin
      ch14q <= ~bus.CHWL_n;
    end else if (bus.CCH14) begin
      ch14q <= '0;
    end else if (done_now) begin
      ch14q[10] <= 1'b0;
    end
  end

  // Magnitude counter: loads outside TORQUE, one decrement per emitted pulse, never below zero.
  always_ff @(posedge SIM_CLK) begin
    if (rst_all) begin
      count <= '0;
    end else if (bus.GYROD_LD && (state != S_TORQUE)) begin
      count <= bus.GYROD_CNT;
    end else if (pulse_start) begin
      count <= count - CNT_W'(1);
    end
  end

  // Pulse timer: sign captured at pulse start, truncated on abort.
  always_ff @(posedge SIM_CLK) begin
    if (rst_all || pulse_abort) begin
      pulse_cnt <= 3'd0;
      pulse_neg <= 1'b0;
    end else if (pulse_start) begin
      pulse_cnt <= 3'(PULSE_W);
      pulse_neg <= sign_minus;
    end else if (pulse_active) begin
      pulse_cnt <= pulse_cnt - 3'd1;
    end
  end

  assign bus.CH14Q     = ch14q;
  assign bus.CHOR14_n  = ~(ch14q & {15{~bus.RCH14_n}});
  assign bus.GYRO_P    = pulse_active & ~pulse_neg;
  assign bus.GYRO_M    = pulse_active & pulse_neg;
  assign bus.GYRO_BUSY = (state == S_ARMED) || (state == S_TORQUE);
  assign bus.GYRO_DONE = done_now;

endmodule
